// File: rtl/muldiv_pkg.sv
// Shared types and sizing helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MULTU = 2'b00,
    MULT  = 2'b01,
    DIVU  = 2'b10,
    DIV   = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CALC   = 2'b01,
    FINISH = 2'b10
  } muldiv_state_e;

  // Iteration counter must hold the value N itself.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO registers.
// Optional MULDIV_SIGNED_EN makes MULT/DIV two's-complement (sign-magnitude around the unsigned core).
module mult_div_unit
  import muldiv_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] wdata,
  input  logic         hi_we,
  input  logic         lo_we,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CW = cnt_width(N);

  muldiv_state_e  state;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] acc;
  logic [N-1:0]   opnd;
  logic           is_div;
  logic           neg_q;
  logic           neg_r;

  muldiv_op_e     op_e;
  logic           op_div;
  logic           sgn_op;
  logic           a_neg, b_neg;
  logic [N-1:0]   a_mag, b_mag;

  assign op_e   = muldiv_op_e'(op);
  assign op_div = (op_e == DIVU) || (op_e == DIV);

`ifdef MULDIV_SIGNED_EN
  assign sgn_op = (op_e == MULT) || (op_e == DIV);
`else
  assign sgn_op = 1'b0;
`endif

  assign a_neg = sgn_op & a[N-1];
  assign b_neg = sgn_op & b[N-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // One iteration step. acc holds {partial product, multiplier} for
  // multiply and {remainder, dividend/quotient} for divide.
  logic [N:0]     add_sum;
  logic [N:0]     sub_trial;
  logic [2*N-1:0] acc_nxt;

  always_comb begin
    add_sum   = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opnd} : {(N+1){1'b0}});
    sub_trial = {acc[2*N-1:N], acc[N-1]} - {1'b0, opnd};
    if (is_div) begin
      if (!sub_trial[N]) acc_nxt = {sub_trial[N-1:0], acc[N-2:0], 1'b1};
      else               acc_nxt = {acc[2*N-2:0], 1'b0};
    end else begin
      acc_nxt = {add_sum, acc[N-1:1]};
    end
  end

  // Sign fix-up of the final step. A zero divisor naturally yields an
  // all-ones magnitude quotient and remainder=|a|, which the fix-up turns
  // into lo=1 / hi=a for a negative dividend.
  logic [2*N-1:0] prod_fix;
  logic [N-1:0]   res_hi, res_lo;

  always_comb begin
    prod_fix = neg_q ? -acc_nxt : acc_nxt;
    if (is_div) begin
      res_lo = neg_q ? -acc_nxt[N-1:0]   : acc_nxt[N-1:0];
      res_hi = neg_r ? -acc_nxt[2*N-1:N] : acc_nxt[2*N-1:N];
    end else begin
      res_lo = prod_fix[N-1:0];
      res_hi = prod_fix[2*N-1:N];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= CALC;
            busy   <= 1'b1;
            cnt    <= CW'(N);
            is_div <= op_div;
            opnd   <= op_div ? b_mag : a_mag;
            acc    <= {{N{1'b0}}, (op_div ? a_mag : b_mag)};
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= op_div & a_neg;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt - CW'(1);
          // Last iteration lands straight in hi/lo so done and the new
          // result become visible together.
          if (cnt == CW'(1)) begin
            state <= FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
            hi    <= res_hi;
            lo    <= res_lo;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected hi/lo, a monitor pops on done.
module tb_mult_div_unit;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst, start, hi_we, lo_we;
  logic [1:0]   op;
  logic [N-1:0] a, b, wdata;
  logic         busy, done;
  logic [N-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  logic [2*N-1:0] sb_q[$];
  string          nm_q[$];
  logic [2*N-1:0] exp_v;
  string          exp_n;

  always #5 clk = ~clk;

  mult_div_unit #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .wdata(wdata), .hi_we(hi_we), .lo_we(lo_we),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got hi=%0h lo=%0h expected no result", hi, lo);
      end else begin
        exp_v = sb_q.pop_front();
        exp_n = nm_q.pop_front();
        chk({exp_n, "_hi"}, 32'(hi), 32'(exp_v[2*N-1:N]));
        chk({exp_n, "_lo"}, 32'(lo), 32'(exp_v[N-1:0]));
      end
    end
  end

  // Issue one op, scramble operands during CALC, check busy trace and latency.
  task automatic run_op(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                        input logic [N-1:0] eh, input logic [N-1:0] el, input string nm);
    int n;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    sb_q.push_back({eh, el});
    nm_q.push_back(nm);
    @(negedge clk);
    start = 1'b0; a = N'($urandom); b = N'($urandom);
    n = 1;
    while (done !== 1'b1 && n < 20) begin
      chk({nm, "_busy"}, 32'(busy), 32'd1);
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'(N + 1));
    chk({nm, "_busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({nm, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    wdata = '0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi",   32'(hi),   32'd0);
    chk("rst_lo",   32'(lo),   32'd0);
    rst = 1'b0;

    run_op(2'b00, 8'd200, 8'd3,   8'h02, 8'h58, "multu_200x3");
    run_op(2'b10, 8'd100, 8'd7,   8'h02, 8'h0E, "divu_100d7");
    run_op(2'b10, 8'h35,  8'h00,  8'h35, 8'hFF, "divu_by_zero");
    repeat (3) @(negedge clk);
    chk("hold_hi", 32'(hi), 32'h35);
    chk("hold_lo", 32'(lo), 32'hFF);

    // Second start during CALC is dropped; writes outside IDLE are dropped.
    start = 1'b1; op = 2'b00; a = 8'd5; b = 8'd5; hi_we = 1'b1; wdata = 8'h99;
    sb_q.push_back({8'h00, 8'h19});
    nm_q.push_back("multu_5x5");
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    chk("start_drops_write", 32'(hi), 32'h35);
    @(negedge clk);
    hi_we = 1'b1; wdata = 8'h77;
    @(negedge clk);
    hi_we = 1'b0; start = 1'b1; op = 2'b10; a = 8'd9; b = 8'd2;
    chk("calc_write_ignored", 32'(hi), 32'h35);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("multu_5x5_done", 32'(done), 32'd1);
    @(negedge clk);
    lo_we = 1'b1; wdata = 8'hAA;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo_lo", 32'(lo), 32'hAA);
    chk("mtlo_hi", 32'(hi), 32'h00);
    repeat (12) @(negedge clk);
    chk("second_start_ignored", 32'(busy), 32'd0);

    run_op(2'b00, 8'hFF, 8'hFF, 8'hFE, 8'h01, "multu_ffxff");
    run_op(2'b10, 8'hFF, 8'h01, 8'h00, 8'hFF, "divu_ffd1");
    run_op(2'b10, 8'h0F, 8'h10, 8'h0F, 8'h00, "divu_small");

`ifdef MULDIV_SIGNED_EN
    run_op(2'b01, 8'hFD, 8'h05, 8'hFF, 8'hF1, "mult_m3x5");
    run_op(2'b11, 8'hF9, 8'h02, 8'hFF, 8'hFD, "div_m7d2");
    run_op(2'b11, 8'h80, 8'hFF, 8'h00, 8'h80, "div_min_dm1");
    run_op(2'b11, 8'hF0, 8'h00, 8'hF0, 8'h01, "div_neg_by_zero");
`else
    run_op(2'b01, 8'hFD, 8'h05, 8'h04, 8'hF1, "mult_as_multu");
    run_op(2'b11, 8'hF9, 8'h02, 8'h01, 8'h7C, "div_as_divu");
`endif

    // Reset in the middle of CALC aborts with no result.
    @(negedge clk);
    hi_we = 1'b1; wdata = 8'h5A;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi_hi", 32'(hi), 32'h5A);
    start = 1'b1; op = 2'b10; a = 8'd100; b = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_hi",   32'(hi),   32'd0);
    chk("abort_lo",   32'(lo),   32'd0);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("abort_no_result", 32'(busy), 32'd0);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
